bmf_h_seq_decoder: RTL
======================

Name: bmf_h_seq_decoder

Overview:
- Sequential decompressor half of a Boolean-matrix-factorised approximate circuit.
- Takes a K-bit latent vector produced by the compressor half and reconstructs the M-bit primary-output vector as the Boolean product of the latent vector with a programmable basis matrix H.
- Processes one factor per cycle, so one shared row-OR datapath serves any K.
- Sits downstream of the latent-generation logic behind a valid/ready interface; H is loadable at runtime so different factorisations can be swapped in.

Parameters:
- K, 4, number of latent factors (rows of H); K >= 1.
- M, 5, number of reconstructed outputs (columns of H); M >= 1.
- H_INIT, 20'h82082, reset contents of H, flattened: row i at bits [i*M +: M]. The default maps factor i to output bit i+1, with output bit 0 always 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  write strobe for one H row.
- cfg_row  input  max(1,$clog2(K))  index of the row to write.
- cfg_data  input  M  new row contents.
- cfg_busy  output  1  high when a cfg write would be ignored (state != IDLE).
- in_valid  input  1  latent vector valid.
- in_ready  output  1  block can accept a latent vector.
- in_k  input  K  latent vector; bit i selects H row i.
- out_valid  output  1  reconstructed vector valid.
- out_ready  input  1  downstream accepts the result.
- out_po  output  M  reconstructed output vector.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, H<=H_INIT, accumulator=0, factor index=0, captured latent=0.
  - Outputs: out_valid=0, out_po=0, in_ready=1, cfg_busy=0.
  - Reset mid-operation aborts the current vector with no output; the next cycle is IDLE.
- States:
  - IDLE: in_ready=1. On in_valid, capture in_k, clear the accumulator, set idx=0, and go to ACCUM.
  - ACCUM: in_ready=0. Each cycle, if k_cap[idx] then acc <= acc | H[idx]; idx <= idx+1. When idx==K-1 the row is applied that cycle, then go to DONE.
  - DONE: out_valid=1 and out_po=acc, both held stable until out_ready. On out_valid&&out_ready, go to IDLE with out_valid cleared the next cycle.
- Latency and throughput:
  - Handshake accepted at edge t; out_valid=1 from edge t+K.
  - Throughput is one vector per K+2 cycles when out_ready is tied high. There is no same-cycle accept-on-drain.
- out_po holds its last value outside DONE; only out_valid is qualifying.
- Configuration:
  - cfg_we is honoured only in IDLE with no in_valid in the same cycle, and is silently dropped otherwise (cfg_busy tells the writer).
  - If cfg_we and in_valid coincide in IDLE, the input wins and the cfg write is dropped; this guarantees H is constant while a vector is being decoded.
  - cfg_row >= K is ignored (no write).
- Zero latent (in_k=0) still takes K cycles and gives out_po=0.
- in_k is sampled only on the accepting edge; later changes have no effect.
- Widths: every operation is an M-bit bitwise operation; there is no carry.

Optional Feature:
- Macro: BMF_H_XOR_EN.
- Defined: accumulation is over GF(2): acc <= acc ^ H[idx] when k_cap[idx]. Every other rule, including timing, is unchanged.
- Undefined: accumulation is Boolean OR, as specified above.

Test Plan:
- Default H, rst then in_k=4'b1010, out_ready=1 -> out_valid asserts exactly 4 cycles after the accept with out_po=5'h14, then returns to IDLE and in_ready=1.
- Default H, in_k=4'b1111, out_ready held 0 for 5 cycles -> out_po=5'h1E stays stable with out_valid=1 the whole time; in_ready stays 0 and a new in_valid is not accepted.
- Write row0=5'h07, row2=5'h0C, then in_k=4'b0101 -> out_po=5'h0F under OR; 5'h0B with BMF_H_XOR_EN.
- cfg_we with cfg_row=1, data=5'h1F issued during ACCUM and again in the same cycle as an IDLE in_valid -> both dropped, cfg_busy=1 during ACCUM. A later in_k=4'b0010 gives 5'h04.
- Assert rst for one cycle at ACCUM cycle 2 of in_k=4'b1111 -> no out_valid, out_po=0, and H is restored to H_INIT (in_k=4'b0001 then gives 5'h02).
- in_k=4'b0000 -> out_valid after 4 cycles with out_po=5'h00. Back-to-back vectors with out_ready=1 are accepted every 6 cycles.

Source files
------------

// File: rtl/bmf_h_seq_decoder.sv
// Sequential decompressor: rebuilds an M-bit output vector as the Boolean product of a
// K-bit latent vector with a run-time loadable basis H, one factor per cycle. Optional macro BMF_H_XOR_EN.
module bmf_h_seq_decoder #(
    parameter int K = 4,
    parameter int M = 5,
    parameter logic [K*M-1:0] H_INIT = 20'h82082,
    localparam int CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_row,
    input  logic [M-1:0]  cfg_data,
    output logic          cfg_busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_po
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

    state_t        state_q;
    logic [M-1:0]  acc_q;
    logic [M-1:0]  po_q;
    logic [CW-1:0] idx_q;
    logic [K-1:0]  kcap_q;
    logic [M-1:0]  h_rows [K];
    logic [M-1:0]  row_sel;
    logic [M-1:0]  row_mix;
    logic [M-1:0]  acc_d;
    logic          cfg_ok;

    // A write only lands in IDLE without a competing input, so H is frozen while decoding.
    assign cfg_ok = cfg_we && (state_q == S_IDLE) && !in_valid && (int'(cfg_row) < K);

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            logic [M-1:0] row_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    row_q <= H_INIT[gi*M +: M];
                end else if (cfg_ok && (cfg_row == CW'(gi))) begin
                    row_q <= cfg_data;
                end
            end
            assign h_rows[gi] = row_q;
        end
    endgenerate

    assign row_sel = h_rows[idx_q];

`ifdef BMF_H_XOR_EN
    assign row_mix = acc_q ^ row_sel;
`else
    assign row_mix = acc_q | row_sel;
`endif

    assign acc_d = kcap_q[idx_q] ? row_mix : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            po_q    <= '0;
            idx_q   <= '0;
            kcap_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        kcap_q  <= in_k;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + CW'(1);
                    if (idx_q == LAST_IDX) begin
                        // Result is latched separately so out_po holds outside DONE.
                        po_q    <= acc_d;
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign cfg_busy  = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_po    = po_q;

endmodule
